smc777_keyboard: RTL
====================

// Module: smc777_keyboard
// PURPOSE
//  Receiving end of the hps_io ps2_key event bus. Decodes each 11-bit key event into an SMC-777 key code
//  and holds it in a show-ahead FIFO. The Z80 I/O decode reads it through pop and status strobes.
//  Sits inside the smc777 core, between hps_io ps2_key and the keyboard I/O port.
// PARAMETERS
//  FIFO_DEPTH  8  entries in key FIFO; power of two, 2..16
// PORTS
//  clk        in   1   system clock (clk_sys); ps2_key and strobes are synchronous to it
//  reset      in   1   asynchronous, active-high reset
//  ps2_key    in   11  [10] toggle on every event, [9] 1=make 0=break, [8] E0-extended, [7:0] scancode
//  rd_data    in   1   one-cycle pop strobe (CPU read of data port)
//  rd_status  in   1   one-cycle strobe (CPU read of status port); clears overflow
//  key_data   out  8   code at FIFO head; 8'h00 when empty
//  key_avail  out  1   FIFO not empty (also used as keyboard IRQ level)
//  key_count  out  $clog2(FIFO_DEPTH)+1  number of stored entries
//  overflow   out  1   sticky: a code was dropped because FIFO was full
//  shift_st   out  1   current shift state;  ctrl_st  out 1  current ctrl state
// BEHAVIOUR
//  Reset (async): FIFO empty, key_data=0, key_avail=0, key_count=0, overflow=0, shift_st=0, ctrl_st=0, init=1.
//  Event detect: first clk edge with init=1 copies ps2_key[10] into last_tog, clears init, raises no event.
//   After that, any edge where ps2_key[10]!=last_tog is one event (E0 cycle); last_tog is updated there.
//  Stage 1 (edge E0): latch make, ext, scancode.
//   Modifiers: 12h or 59h sets/clears shift_st per make; 14h (ext or not) sets/clears ctrl_st. No push.
//   Break of any other key: no push.
//  Stage 2 (edge E0+1): translate the latched make and push. key_avail/key_data are valid after edge E0+1.
//  Translation (non-ext unless noted; all others are dropped, no push, no overflow):
//   letters 1Ch=A 32h=B 21h=C 23h=D 24h=E 2Bh=F 34h=G 33h=H 43h=I 3Bh=J 42h=K 4Bh=L 3Ah=M
//           31h=N 44h=O 4Dh=P 15h=Q 2Dh=R 1Bh=S 2Ch=T 3Ch=U 2Ah=V 1Dh=W 22h=X 35h=Y 1Ah=Z
//    -> ctrl: 01h..1Ah; else shift: 41h..5Ah; else 61h..7Ah  (ctrl has priority over shift)
//   digits 45h,16h,1Eh,26h,25h,2Eh,36h,3Dh,3Eh,46h -> 30h..39h; shift and ctrl are ignored
//   5Ah->0Dh  29h->20h  66h->08h  76h->1Bh  0Dh->09h
//   ext 75h->1Eh  ext 72h->1Fh  ext 6Bh->1Dh  ext 74h->1Ch; ext 5Ah (keypad enter)->0Dh
//  Typematic repeats arrive as repeated make events; each one is pushed.
//  FIFO: show-ahead; key_data = head entry combinationally from registered storage.
//   rd_data when empty is ignored. Push and pop in the same cycle: both occur, count is unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//   Push when full (no simultaneous pop): code is dropped, overflow<=1, FIFO unchanged.
//   Push when full with simultaneous pop: accepted, no overflow.
//  overflow clears on rd_status; if set and clear occur in the same cycle, set wins.
//  Events arriving on consecutive cycles are each processed, since stage 1 and stage 2 are pipelined.
//  Reset asserted mid-event: the pending stage-1 event is discarded; init re-arms.
// TESTING
//  1) Reset release with ps2_key[10]=1 held, no toggle for 100 cycles -> key_avail=0, key_count=0.
//  2) Make 1Ch ('A') -> key_data=61h 2 edges after toggle; shift make 12h then 1Ch -> 41h;
//     ctrl 14h+shift+1Ch -> 01h. Break 1Ch -> nothing pushed.
//  3) Ext make 75h -> 1Eh. Non-ext 75h and unmapped 05h -> no push, count unchanged.
//  4) 9 makes of 29h with DEPTH=8, no reads -> key_count=8, overflow=1.
//     rd_status -> overflow=0. 8 x rd_data -> each 20h, then key_data=00h, key_avail=0.
//  5) FIFO full, push and rd_data in the same cycle -> count stays 8, overflow stays 0.
//     rd_data on empty -> no change.
//  6) Two toggles on consecutive cycles (16h then 1Eh) -> FIFO holds 31h then 32h.
//     Reset asserted 1 cycle after a toggle -> FIFO empty, no entry appears.

Source files
------------

// File: rtl/smc777_keyboard.sv
// rtl/smc777_keyboard.sv - ps2_key event decoder feeding a show-ahead SMC-777 key code FIFO
module smc777_keyboard #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [10:0]                 ps2_key,
    input  logic                        rd_data,
    input  logic                        rd_status,
    output logic [7:0]                  key_data,
    output logic                        key_avail,
    output logic [$clog2(FIFO_DEPTH):0] key_count,
    output logic                        overflow,
    output logic                        shift_st,
    output logic                        ctrl_st
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic          init_q, init_d;
    logic          last_tog_q, last_tog_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_ext_q, s1_ext_d;
    logic [7:0]    s1_code_q, s1_code_d;
    logic          shift_q, shift_d;
    logic          ctrl_q, ctrl_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          ev, is_shift_key, is_ctrl_key;
    logic          tr_hit;
    logic [7:0]    tr_code;
    logic [4:0]    lidx;
    logic          empty, full, pop, push_req, push_ok;

    assign ev           = !init_q && (ps2_key[10] != last_tog_q);
    assign is_shift_key = (ps2_key[7:0] == 8'h12) || (ps2_key[7:0] == 8'h59);
    assign is_ctrl_key  = (ps2_key[7:0] == 8'h14);

    // Stage 1: event detection, modifier tracking and latching of the key
    always_comb begin
        init_d     = 1'b0;
        last_tog_d = last_tog_q;
        s1_valid_d = 1'b0;
        s1_ext_d   = s1_ext_q;
        s1_code_d  = s1_code_q;
        shift_d    = shift_q;
        ctrl_d     = ctrl_q;
        if (init_q) begin
            last_tog_d = ps2_key[10];
        end else if (ev) begin
            last_tog_d = ps2_key[10];
            s1_ext_d   = ps2_key[8];
            s1_code_d  = ps2_key[7:0];
            if (is_shift_key) begin
                shift_d = ps2_key[9];
            end else if (is_ctrl_key) begin
                ctrl_d = ps2_key[9];
            end else begin
                s1_valid_d = ps2_key[9];
            end
        end
    end

    // Stage 2 translation; lidx 31 marks "not a letter"
    always_comb begin
        tr_hit  = 1'b1;
        tr_code = 8'h00;
        lidx    = 5'd31;
        if (s1_ext_q) begin
            case (s1_code_q)
                8'h75:   tr_code = 8'h1E;
                8'h72:   tr_code = 8'h1F;
                8'h6B:   tr_code = 8'h1D;
                8'h74:   tr_code = 8'h1C;
                8'h5A:   tr_code = 8'h0D;
                default: tr_hit  = 1'b0;
            endcase
        end else begin
            case (s1_code_q)
                8'h1C: lidx = 5'd0;   8'h32: lidx = 5'd1;   8'h21: lidx = 5'd2;
                8'h23: lidx = 5'd3;   8'h24: lidx = 5'd4;   8'h2B: lidx = 5'd5;
                8'h34: lidx = 5'd6;   8'h33: lidx = 5'd7;   8'h43: lidx = 5'd8;
                8'h3B: lidx = 5'd9;   8'h42: lidx = 5'd10;  8'h4B: lidx = 5'd11;
                8'h3A: lidx = 5'd12;  8'h31: lidx = 5'd13;  8'h44: lidx = 5'd14;
                8'h4D: lidx = 5'd15;  8'h15: lidx = 5'd16;  8'h2D: lidx = 5'd17;
                8'h1B: lidx = 5'd18;  8'h2C: lidx = 5'd19;  8'h3C: lidx = 5'd20;
                8'h2A: lidx = 5'd21;  8'h1D: lidx = 5'd22;  8'h22: lidx = 5'd23;
                8'h35: lidx = 5'd24;  8'h1A: lidx = 5'd25;
                8'h45: tr_code = 8'h30;  8'h16: tr_code = 8'h31;  8'h1E: tr_code = 8'h32;
                8'h26: tr_code = 8'h33;  8'h25: tr_code = 8'h34;  8'h2E: tr_code = 8'h35;
                8'h36: tr_code = 8'h36;  8'h3D: tr_code = 8'h37;  8'h3E: tr_code = 8'h38;
                8'h46: tr_code = 8'h39;
                8'h5A: tr_code = 8'h0D;  8'h29: tr_code = 8'h20;  8'h66: tr_code = 8'h08;
                8'h76: tr_code = 8'h1B;  8'h0D: tr_code = 8'h09;
                default: tr_hit = 1'b0;
            endcase
            if (lidx != 5'd31) begin
                if (ctrl_q)       tr_code = 8'h01 + {3'b000, lidx};
                else if (shift_q) tr_code = 8'h41 + {3'b000, lidx};
                else              tr_code = 8'h61 + {3'b000, lidx};
            end
        end
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = rd_data && !empty;
    assign push_req = s1_valid_q && tr_hit;
    // A pop in the same cycle frees the slot the push needs
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = tr_code;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push_ok) count_d = count_q - CW'(1);
        if (rd_status) ovf_d = 1'b0;
        if (push_req && !push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_q     <= 1'b1;
            last_tog_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_ext_q   <= 1'b0;
            s1_code_q  <= 8'h00;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            init_q     <= init_d;
            last_tog_q <= last_tog_d;
            s1_valid_q <= s1_valid_d;
            s1_ext_q   <= s1_ext_d;
            s1_code_q  <= s1_code_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign key_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign key_avail = !empty;
    assign key_count = count_q;
    assign overflow  = ovf_q;
    assign shift_st  = shift_q;
    assign ctrl_st   = ctrl_q;
endmodule
